inv_sub_bytes_seq: RTL and testbench



---
 rtl/inv_sub_bytes_seq.sv | 134 +++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes engine: LANES bytes per cycle between valid/ready handshakes.
// Define INV_SUB_BYTES_FWD_EN to add a fwd input that selects the forward S-box per state.
module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
`ifdef INV_SUB_BYTES_FWD_EN
  ,
  input  logic         fwd
`endif
);

  localparam int PASSES = 16 / LANES;
  localparam int CW     = $clog2(PASSES + 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  // Entry x lives at bits [2047-8x -: 8], so the first listed byte is entry 0.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb, 128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e, 128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692, 128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506, 128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673, 128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b, 128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f, 128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961, 128'h172b047e_ba77d626_e1691463_55210c7d
  };

`ifdef INV_SUB_BYTES_FWD_EN
  localparam logic [2047:0] FWD_SBOX = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76, 128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115, 128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84, 128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8, 128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973, 128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479, 128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a, 128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df, 128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  logic fwd_q;

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic f);
    return f ? FWD_SBOX[11'd2047 - {b, 3'b000} -: 8] : INV_SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction
`else
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return INV_SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [127:0]    work;
  logic [127:0]    next_work;
  logic [CW-1:0]   cnt;

  always_comb begin
    logic [3:0] pos;
    next_work = work;
    pos       = '0;
    for (int l = 0; l < LANES; l++) begin
      pos = 4'(int'(cnt) * LANES + l);
`ifdef INV_SUB_BYTES_FWD_EN
      next_work[7'd127 - {pos, 3'b000} -: 8] = sub_byte(work[7'd127 - {pos, 3'b000} -: 8], fwd_q);
`else
      next_work[7'd127 - {pos, 3'b000} -: 8] = sub_byte(work[7'd127 - {pos, 3'b000} -: 8]);
`endif
    end
  end

  // cnt runs 0..PASSES-1 substituting lanes; the extra cnt==PASSES cycle publishes the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      out_state <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
`ifdef INV_SUB_BYTES_FWD_EN
      fwd_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            work     <= in_state;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= BUSY;
`ifdef INV_SUB_BYTES_FWD_EN
            fwd_q    <= fwd;
`endif
          end
        end
        BUSY: begin
          if (cnt == CW'(PASSES)) begin
            out_state <= work;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            work <= next_work;
            cnt  <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq: one instance per legal LANES value,
// checked against S-boxes derived from GF(2^8) inversion plus the AES affine map.
module tb_inv_sub_bytes_seq;

  localparam int NCFG = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid_a  [NCFG];
  logic         in_ready_a  [NCFG];
  logic [127:0] in_state_a  [NCFG];
  logic         out_valid_a [NCFG];
  logic         out_ready_a [NCFG];
  logic [127:0] out_state_a [NCFG];
  logic         busy_a      [NCFG];
`ifdef INV_SUB_BYTES_FWD_EN
  logic         fwd_a       [NCFG];
`endif

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    inv_sub_bytes_seq #(.LANES(1 << g)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .in_state  (in_state_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .out_state (out_state_a[g]),
      .busy      (busy_a[g])
`ifdef INV_SUB_BYTES_FWD_EN
      ,
      .fwd       (fwd_a[g])
`endif
    );
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input bit f);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++)
      r[127 - 8*i -: 8] = f ? sbox_t[d[127 - 8*i -: 8]] : isbox_t[d[127 - 8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one state through instance k; lat counts edges from acceptance to out_valid.
  task automatic run_state(input int k, input logic [127:0] data, input int hold,
                           output logic [127:0] res, output int lat);
    int n = 0;
    in_state_a[k]  = data;
    in_valid_a[k]  = 1'b1;
    out_ready_a[k] = (hold == 0);
    while (!in_ready_a[k] && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid_a[k] = 1'b0;
    in_state_a[k] = rand128();
`ifdef INV_SUB_BYTES_FWD_EN
    fwd_a[k] = 1'($urandom);
`endif
    lat = 0;
    while (!out_valid_a[k] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_state_a[k];
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready_a[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NCFG; k++) begin
      checks++;
      if (in_ready_a[k] !== 1'b1 || out_valid_a[k] !== 1'b0 || busy_a[k] !== 1'b0 ||
          out_state_a[k] !== 128'h0) begin
        errors++;
        $display("[TB] FAIL reset lanes=%0d: got rdy=%b vld=%b busy=%b out=%h expected 1 0 0 0",
                 1 << k, in_ready_a[k], out_valid_a[k], busy_a[k], out_state_a[k]);
      end
    end
  endtask

  task automatic test_key_values();
    logic [127:0] res;
    int lat;
    run_state(2, 128'h637c0016_52ed6363_63636363_63636363, 0, res, lat);
    checks++;
    if (res !== 128'h000152ff_48530000_00000000_00000000) begin
      errors++;
      $display("[TB] FAIL key_values: got %h expected %h", res,
               128'h000152ff_48530000_00000000_00000000);
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("[TB] FAIL key_latency: got %0d expected 5", lat);
    end
    checks++;
    if (in_ready_a[2] !== 1'b1 || out_valid_a[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL key_release: got rdy=%b vld=%b expected rdy=1 vld=0",
               in_ready_a[2], out_valid_a[2]);
    end
  endtask

  task automatic test_bijection();
    int perm [256];
    int j;
    int tmp;
    logic [127:0] din;
    logic [127:0] want;
    logic [127:0] res;
    int lat;
    for (int k = 0; k < NCFG; k++) begin
      for (int i = 0; i < 256; i++) perm[i] = i;
      for (int i = 255; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      for (int s = 0; s < 16; s++) begin
        for (int b = 0; b < 16; b++) begin
          din[127 - 8*b -: 8]  = sbox_t[perm[16*s + b]];
          want[127 - 8*b -: 8] = 8'(perm[16*s + b]);
        end
        run_state(k, din, 0, res, lat);
        checks++;
        if (res !== want) begin
          errors++;
          $display("[TB] FAIL bijection lanes=%0d state=%0d: got %h expected %h",
                   1 << k, s, res, want);
        end
        checks++;
        if (lat !== (16 >> k) + 1) begin
          errors++;
          $display("[TB] FAIL bijection_latency lanes=%0d: got %0d expected %0d",
                   1 << k, lat, (16 >> k) + 1);
        end
      end
    end
  endtask

  task automatic test_random();
    int k;
    logic [127:0] din;
    logic [127:0] res;
    int lat;
    for (int it = 0; it < 20; it++) begin
      k   = int'($urandom_range(0, NCFG - 1));
      din = rand128();
`ifdef INV_SUB_BYTES_FWD_EN
      fwd_a[k] = 1'b0;
`endif
      run_state(k, din, int'($urandom_range(0, 3)), res, lat);
      checks++;
      if (res !== model(din, 1'b0) || lat !== (16 >> k) + 1) begin
        errors++;
        $display("[TB] FAIL random lanes=%0d: got %h lat %0d expected %h lat %0d",
                 1 << k, res, lat, model(din, 1'b0), (16 >> k) + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] din = rand128();
    logic [127:0] want;
    int n = 0;
    want = model(din, 1'b0);
`ifdef INV_SUB_BYTES_FWD_EN
    fwd_a[2] = 1'b0;
`endif
    in_state_a[2]  = din;
    in_valid_a[2]  = 1'b1;
    out_ready_a[2] = 1'b0;
    @(posedge clk); #1;
    in_valid_a[2] = 1'b0;
    while (!out_valid_a[2] && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    in_state_a[2] = rand128();
    in_valid_a[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_state_a[2] !== want || out_valid_a[2] !== 1'b1 || in_ready_a[2] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL backpressure cycle=%0d: got out=%h vld=%b rdy=%b expected out=%h vld=1 rdy=0",
                 c, out_state_a[2], out_valid_a[2], in_ready_a[2], want);
      end
      @(posedge clk); #1;
    end
    in_valid_a[2]  = 1'b0;
    out_ready_a[2] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[2] = 1'b0;
    checks++;
    if (out_valid_a[2] !== 1'b0 || in_ready_a[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL backpressure_release: got vld=%b rdy=%b expected vld=0 rdy=1",
               out_valid_a[2], in_ready_a[2]);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_a[2] !== 1'b0 || in_ready_a[2] !== 1'b1 || out_valid_a[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_single: got busy=%b rdy=%b vld=%b expected 0 1 0",
               busy_a[2], in_ready_a[2], out_valid_a[2]);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] din = rand128();
    logic [127:0] res;
    int lat;
`ifdef INV_SUB_BYTES_FWD_EN
    fwd_a[2] = 1'b0;
`endif
    in_state_a[2] = din;
    in_valid_a[2] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[2] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy_a[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_busy: got %b expected 1", busy_a[2]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready_a[2] !== 1'b1 || out_valid_a[2] !== 1'b0 || busy_a[2] !== 1'b0 ||
        out_state_a[2] !== 128'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got rdy=%b vld=%b busy=%b out=%h expected 1 0 0 0",
               in_ready_a[2], out_valid_a[2], busy_a[2], out_state_a[2]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    din = rand128();
    run_state(2, din, 0, res, lat);
    checks++;
    if (res !== model(din, 1'b0) || lat !== 5) begin
      errors++;
      $display("[TB] FAIL mid_recover: got %h lat %0d expected %h lat 5",
               res, lat, model(din, 1'b0));
    end
  endtask

`ifdef INV_SUB_BYTES_FWD_EN
  task automatic test_fwd();
    logic [127:0] res;
    logic [127:0] din;
    int lat;
    int k;
    bit f;
    fwd_a[2] = 1'b1;
    run_state(2, 128'h0, 0, res, lat);
    checks++;
    if (res !== {16{8'h63}} || lat !== 5) begin
      errors++;
      $display("[TB] FAIL fwd_zero: got %h lat %0d expected %h lat 5", res, lat, {16{8'h63}});
    end
    fwd_a[2] = 1'b0;
    run_state(2, {16{8'h63}}, 0, res, lat);
    checks++;
    if (res !== 128'h0 || lat !== 5) begin
      errors++;
      $display("[TB] FAIL fwd_inverse: got %h lat %0d expected 0 lat 5", res, lat);
    end
    for (int it = 0; it < 10; it++) begin
      k   = int'($urandom_range(0, NCFG - 1));
      f   = 1'($urandom);
      din = rand128();
      fwd_a[k] = f;
      run_state(k, din, 0, res, lat);
      checks++;
      if (res !== model(din, f) || lat !== (16 >> k) + 1) begin
        errors++;
        $display("[TB] FAIL fwd_random lanes=%0d fwd=%0d: got %h lat %0d expected %h lat %0d",
                 1 << k, f, res, lat, model(din, f), (16 >> k) + 1);
      end
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NCFG; k++) begin
      in_valid_a[k]  = 1'b0;
      out_ready_a[k] = 1'b0;
      in_state_a[k]  = '0;
`ifdef INV_SUB_BYTES_FWD_EN
      fwd_a[k]       = 1'b0;
`endif
    end
    build_tables();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_key_values();
    test_bijection();
    test_random();
    test_backpressure();
    test_reset_mid();
`ifdef INV_SUB_BYTES_FWD_EN
    test_fwd();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
